// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared widths, halt word, fetch state and packet types
package riscv_fetch_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] HALT_WORD = 32'd0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// rtl/fetch_skid_fifo.sv - 2-entry fetch packet buffer with push/pop/flush
module fetch_skid_fifo
    import riscv_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_pkt_t push_pkt,
    output fetch_pkt_t head,
    output logic [1:0] count
);

    fetch_pkt_t mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic       do_pop;

    assign do_pop = pop && (count_q != 2'd0);
    assign head   = mem_q[rd_ptr_q];
    assign count  = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_pkt;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(push && (count_q == 2'd2) && !do_pop));
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, imem request issue and decode handshake
module instruction_fetch
    import riscv_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              req_q, req_d;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    logic              issue, pop, push, arrive, halt_word;
    fetch_pkt_t        head, push_pkt;

    assign imem_addr = redirect_valid ? redirect_pc : pc_q;
    assign out_valid = (count != 2'd0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign halted    = (state_q == HALT) && !redirect_valid;

    // A redirect discards whatever word the memory returns this cycle.
    assign arrive    = req_q && !redirect_valid;
    assign halt_word = arrive && (imem_data == HALT_WORD);
    assign push      = arrive && !halt_word;
    assign push_pkt  = '{pc: req_pc_q, instr: imem_data};

    // Buffered plus in-flight packets after this cycle's pop; keep it below 2.
    assign occupancy = {1'b0, count} + {2'b00, req_q} - {2'b00, pop};

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        if (redirect_valid) begin
            state_d = RUN;
            issue   = 1'b1;
        end else if (state_q == RUN) begin
            if (halt_word) begin
                state_d = HALT;
            end else begin
                issue = (occupancy < 3'd2);
            end
        end
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        req_d    = issue;
        if (issue) begin
            pc_d     = imem_addr + ADDR_W'(1);
            req_pc_d = imem_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= '0;
            req_q    <= 1'b0;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_skid_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .push_pkt (push_pkt),
        .head     (head),
        .count    (count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;
    import riscv_fetch_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              halted;

    logic [DATA_W-1:0] mem [32];
    int n_cmp = 0;
    int n_bad = 0;
    int nacc;
    int maxc;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pkt(input string tag, input int pc, input logic [31:0] instr);
        expect_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
        expect_eq({tag, ".pc"},    64'(out_pc),    64'(pc));
        expect_eq({tag, ".instr"}, 64'(out_instr), 64'(instr));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic fill(input logic [31:0] base, input int zero_at);
        for (int k = 0; k < 32; k++) mem[k] = base + 32'(k);
        if (zero_at >= 0) mem[zero_at] = 32'd0;
    endtask

    // Leaves the bench in cycle 0: the first cycle with rst_n high.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        fill(32'h100, 25);
        #1 rst_n = 1'b0;
        #2;
        expect_eq("rst.imem_addr", 64'(imem_addr), 64'd0);
        expect_eq("rst.out_valid", 64'(out_valid), 64'd0);
        expect_eq("rst.halted",    64'(halted),    64'd0);
        expect_eq("rst.out_instr", 64'(out_instr), 64'd0);
        expect_eq("rst.out_pc",    64'(out_pc),    64'd0);

        // Streaming to the halt word at address 25
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        sample();
        expect_eq("s.issue0", 64'(imem_addr), 64'd0);
        for (int c = 1; c <= 30; c++) begin
            next_cycle();
            sample();
            if (c < 2) begin
                expect_eq("s.lat", 64'(out_valid), 64'd0);
            end else if (c <= 26) begin
                expect_pkt("s.pkt", c - 2, 32'h100 + 32'(c - 2));
                if (c == 26) expect_eq("s.halt_early", 64'(halted), 64'd0);
            end else begin
                expect_eq("s.halted", 64'(halted), 64'd1);
                expect_eq("s.drained", 64'(out_valid), 64'd0);
            end
        end

        // out_ready pattern 1,0,0,1
        do_reset();
        nacc = 0;
        maxc = 0;
        for (int c = 0; c < 300 && nacc < 25; c++) begin
            if (c > 0) next_cycle();
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            sample();
            if (int'(dut.count) > maxc) maxc = int'(dut.count);
            if (out_valid && out_ready) begin
                expect_eq("st.pc",    64'(out_pc),    64'(nacc));
                expect_eq("st.instr", 64'(out_instr), 64'(32'h100 + 32'(nacc)));
                nacc++;
            end
        end
        expect_eq("st.accepted", 64'(nacc), 64'd25);
        expect_eq("st.count_le2", 64'(maxc <= 2), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) next_cycle();
        sample();
        expect_eq("st.drained", 64'(out_valid), 64'd0);

        // Redirect to 20 while pc 5 is at the head, then halt and redirect to 3
        do_reset();
        for (int c = 1; c <= 6; c++) next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 5'd20;
        sample();
        expect_eq("r.head_pc",   64'(out_pc),    64'd5);
        expect_eq("r.no_accept", 64'(out_valid), 64'd0);
        expect_eq("r.addr",      64'(imem_addr), 64'd20);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        expect_eq("r.bubble", 64'(out_valid), 64'd0);
        for (int k = 20; k <= 24; k++) begin
            next_cycle();
            sample();
            expect_pkt("r.pkt", k, 32'h100 + 32'(k));
        end
        expect_eq("r.halt_early", 64'(halted), 64'd0);
        next_cycle();
        sample();
        expect_eq("h.halted", 64'(halted),    64'd1);
        expect_eq("h.valid",  64'(out_valid), 64'd0);
        next_cycle();
        next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 5'd3;
        sample();
        expect_eq("h.halt_fall", 64'(halted),    64'd0);
        expect_eq("h.addr",      64'(imem_addr), 64'd3);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        expect_eq("h.bubble",  64'(out_valid), 64'd0);
        expect_eq("h.running", 64'(halted),    64'd0);
        next_cycle();
        sample();
        expect_pkt("h.pkt3", 3, 32'h103);
        next_cycle();
        sample();
        expect_pkt("h.pkt4", 4, 32'h104);

        // PC wrap-around from 30
        fill(32'h200, -1);
        do_reset();
        for (int c = 1; c <= 2; c++) next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 5'd30;
        next_cycle();
        redirect_valid = 1'b0;
        next_cycle();
        sample();
        expect_pkt("w.pkt30", 30, 32'h21e);
        next_cycle();
        sample();
        expect_pkt("w.pkt31", 31, 32'h21f);
        next_cycle();
        sample();
        expect_pkt("w.pkt0", 0, 32'h200);
        next_cycle();
        sample();
        expect_pkt("w.pkt1", 1, 32'h201);

        // Asynchronous reset mid-stream
        fill(32'h100, 25);
        do_reset();
        for (int c = 1; c <= 5; c++) next_cycle();
        sample();
        expect_pkt("a.pre", 3, 32'h103);
        rst_n = 1'b0;
        #1;
        expect_eq("a.valid",  64'(out_valid), 64'd0);
        expect_eq("a.halted", 64'(halted),    64'd0);
        expect_eq("a.addr",   64'(imem_addr), 64'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        sample();
        expect_eq("a.issue0", 64'(imem_addr), 64'd0);
        expect_eq("a.valid0", 64'(out_valid), 64'd0);
        next_cycle();
        sample();
        expect_eq("a.valid1", 64'(out_valid), 64'd0);
        next_cycle();
        sample();
        expect_pkt("a.pkt0", 0, 32'h100);
        next_cycle();
        sample();
        expect_pkt("a.pkt1", 1, 32'h101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that sits directly upstream of the synchronous-read instruction memory and directly upstream of decode. It owns the program counter and drives the memory word address. It absorbs the memory's 1-cycle read latency with a 2-entry skid buffer and presents {pc, instruction} to decode over a valid/ready handshake. It supports PC redirect (for future branch/jump types) and halts on an all-zero instruction word.

## Interface
- ADDR_W, 5: word-address width; PC is a word index.
- DATA_W, 32: instruction width.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- imem_addr  out  ADDR_W: word address to instruction memory; the memory registers its output at the next rising edge.
- imem_data  in  DATA_W: memory read data, valid the cycle after its address was driven.
- redirect_valid  in  1: load a new PC this cycle and flush.
- redirect_pc  in  ADDR_W: new PC.
- out_valid  out  1: fetch packet available to decode.
- out_ready  in  1: decode accepts the packet.
- out_instr  out  DATA_W: instruction word.
- out_pc  out  ADDR_W: word address of out_instr.
- halted  out  1: fetch stopped on a zero word.

## Operation
- State machine with two states, RUN and HALT. Reset enters RUN.
- Registers:
  - pc_q: next address to issue.
  - req_q: 1 when the previous cycle issued a fetch.
  - req_pc_q: PC of that fetch.
  - 2-entry FIFO of {pc, instr} with count 0..2.
- imem_addr = redirect_valid ? redirect_pc : pc_q. This is combinational from registers and the redirect inputs.
- Handshake:
  - pop = out_valid & out_ready.
  - out_valid = (count != 0) & !redirect_valid.
  - out_instr and out_pc come from the FIFO head.
  - out_instr and out_pc hold stable while out_valid & !out_ready.
- Issue rule in RUN: issue = redirect_valid | ((count + req_q - pop) < 2).
  - On issue, pc_q <= imem_addr + 1, modulo 2^ADDR_W (31 wraps to 0).
  - req_q <= 1 and req_pc_q <= imem_addr.
  - No issue leaves pc_q unchanged and sets req_q <= 0.
- Arrival: when req_q = 1, imem_data is the word at req_pc_q.
  - Nonzero word: pushed into the FIFO as {req_pc_q, imem_data}.
  - 32'd0: not pushed. State becomes HALT, no further issues occur, and halted = 1. FIFO contents still drain to decode.
- In HALT, imem_addr still shows pc_q, but no request is tracked.
- Redirect (any state):
  - FIFO is cleared and the in-flight arrival in the same cycle is discarded.
  - A fetch from redirect_pc is issued that cycle and the state returns to RUN.
  - No handshake completes in a redirect cycle.
- Push, pop and arrival can occur in the same cycle. The issue rule guarantees the FIFO never overflows. A push to a full FIFO is an assertion failure.

## Timing
- Reset values:
  - pc_q = 0, req_q = 0, count = 0, state RUN.
  - imem_addr = 0, out_valid = 0, halted = 0.
  - out_instr and out_pc = 0.
- The first issue (address 0) occurs in the first cycle after rst_n deasserts.
- Latency from issue to out_valid is 2 cycles: issue in cycle t, data in cycle t+1, FIFO output in cycle t+2.
- Steady state with out_ready held high: one packet per cycle, with PCs consecutive and wrapping at 31 to 0.
- Stall: out_ready low for N cycles keeps at most 2 buffered packets with no loss or duplication. Throughput resumes the cycle after out_ready rises.
- Redirect in cycle t: out_valid = 0 in cycles t and t+1. The packet for redirect_pc appears in cycle t+2.
- Reset asserted mid-operation clears all state immediately (asynchronous). In-flight data is ignored after release.

## Structure
- Shared package riscv_fetch_pkg holds:
  - ADDR_W and DATA_W defaults.
  - HALT_WORD = 32'd0.
  - The fetch state enum {RUN, HALT}.
  - The fetch packet struct {pc, instr}.
- One sub-module, fetch_skid_fifo: a 2-entry synchronous FIFO with push/pop/flush, count output, and asynchronous active-low reset.

## Test plan
- Behavioural memory model with mem[k] = 32'h100 + k for k = 0..24 and mem[25] = 0, out_ready held at 1, reset released: packets pc 0..24 arrive with instr 32'h100..32'h118, one per cycle, first at cycle 2. halted rises 1 cycle after address 25 is read, and out_valid stays 0 afterwards.
- out_ready toggles 1,0,0,1 repeating: the sequence of accepted (pc, instr) pairs equals 0..24 in order with no gaps or duplicates. count never exceeds 2.
- redirect_valid pulsed with redirect_pc = 20 while pc 5 is at the FIFO head and out_ready = 1: pc 5 is not accepted, the next accepted packet is pc 20 exactly 2 cycles later, followed by 21, 22, and so on.
- Halt at pc 25, then redirect_pc = 3: state returns to RUN, halted falls in the redirect cycle, and pc 3 is delivered 2 cycles later.
- Memory filled with nonzero words, redirect_pc = 30: delivered PCs are 30, 31, 0, 1 (wrap-around).
- rst_n asserted mid-stream for 1 cycle while out_valid = 1: out_valid, halted and imem_addr go to 0 immediately. After release, fetch restarts at pc 0.
